// File: rtl/event_queue_mc.sv
// event_queue_mc: multi-channel time-ordered event queue.
// Each channel is a sorted compare-and-shift array; a registered selector
// tracks the globally earliest head so a read pops it in a single edge.
// Optional build macro: EQ_TIME_WRAP_EN selects wrap-around (serial) TIME
// comparison instead of plain unsigned comparison.
module event_queue_mc #(
  parameter int unsigned data_wd   = 32,
  parameter int unsigned q_add_wd  = 4,
  parameter int unsigned q_max_len = 16,
  parameter int unsigned n_ch      = 4,
  parameter int unsigned ch_wd     = 2,
  parameter int unsigned hi        = 15,
  parameter int unsigned lo        = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [data_wd-1:0]        EV_in,
  input  logic [ch_wd-1:0]          ch,
  input  logic                      op,
  input  logic                      cs,
  input  logic                      flush,
  output logic [data_wd-1:0]        EV_out,
  output logic [ch_wd-1:0]          EV_ch,
  output logic                      dv,
  output logic [n_ch-1:0]           full,
  output logic                      empty,
  output logic                      busy_for_rd,
  output logic                      busy_for_wr,
  output logic                      ovf,
  output logic                      udf,
  output logic [q_add_wd+ch_wd:0]   length
);

  localparam int unsigned tm_wd  = hi - lo + 1;
  localparam int unsigned cnt_wd = q_add_wd + 1;
  localparam int unsigned len_wd = q_add_wd + ch_wd + 1;

  // True when TIME a is strictly earlier than TIME b.
  function automatic logic t_before(input logic [tm_wd-1:0] a,
                                    input logic [tm_wd-1:0] b);
`ifdef EQ_TIME_WRAP_EN
    logic [tm_wd-1:0] diff;
    diff = a - b;
    return diff[tm_wd-1];
`else
    return a < b;
`endif
  endfunction

  // Storage and per-channel occupancy
  logic [data_wd-1:0] mem_q [n_ch][q_max_len];
  logic [data_wd-1:0] mem_d [n_ch][q_max_len];
  logic [cnt_wd-1:0]  cnt_q [n_ch];
  logic [cnt_wd-1:0]  cnt_d [n_ch];

  // Global-minimum selector
  logic [data_wd-1:0] sel_q, sel_d;
  logic [ch_wd-1:0]   sel_ch_q, sel_ch_d;
  logic               sel_found;

  // Output and status registers
  logic [data_wd-1:0] ev_out_q, ev_out_d;
  logic [ch_wd-1:0]   ev_ch_q, ev_ch_d;
  logic               dv_q, dv_d;
  logic [n_ch-1:0]    full_q, full_d;
  logic               empty_q, empty_d;
  logic               brd_q, brd_d;
  logic               bwr_q, bwr_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;
  logic [len_wd-1:0]  len_q, len_d;

  // Request decode
  logic               ch_ok, ch_full;
  logic               wr_req, wr_ok, rd_req, rd_ok;
  logic [q_max_len-1:0] aft;

  // Operation decode and acceptance
  always_comb begin
    ch_ok   = (32'(ch) < n_ch);
    ch_full = !ch_ok || (cnt_q[ch] == cnt_wd'(q_max_len));
    wr_req  = cs && op && !flush;
    rd_req  = cs && !op && !flush;
    wr_ok   = wr_req && !bwr_q && ch_ok && !ch_full;
    rd_ok   = rd_req && !brd_q && !empty_q;
  end

  // Insertion point: slot i is at or after the new entry's position when it is
  // unused or holds a strictly later TIME (so equal TIMEs stay FIFO).
  always_comb begin
    aft = '0;
    for (int i = 0; i < int'(q_max_len); i++) begin
      aft[i] = !(cnt_wd'(i) < cnt_q[ch]) ||
               t_before(EV_in[hi:lo], mem_q[ch][i][hi:lo]);
    end
  end

  // Next-state for storage, counters and registered outputs
  always_comb begin
    mem_d    = mem_q;
    cnt_d    = cnt_q;
    ev_out_d = ev_out_q;
    ev_ch_d  = ev_ch_q;
    dv_d     = 1'b0;
    brd_d    = 1'b0;
    bwr_d    = 1'b0;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
    len_d    = '0;
    full_d   = '0;
    empty_d  = 1'b1;

    if (flush) begin
      for (int c = 0; c < int'(n_ch); c++) begin
        cnt_d[c] = '0;
      end
      bwr_d = 1'b1;
    end else if (wr_ok) begin
      if (aft[0]) begin
        mem_d[ch][0] = EV_in;
      end
      for (int i = 1; i < int'(q_max_len); i++) begin
        if (aft[i]) begin
          mem_d[ch][i] = aft[i-1] ? mem_q[ch][i-1] : EV_in;
        end
      end
      cnt_d[ch] = cnt_q[ch] + cnt_wd'(1);
      brd_d     = 1'b1;
    end else if (rd_ok) begin
      ev_out_d = sel_q;
      ev_ch_d  = sel_ch_q;
      dv_d     = 1'b1;
      for (int i = 0; i < int'(q_max_len) - 1; i++) begin
        mem_d[sel_ch_q][i] = mem_q[sel_ch_q][i+1];
      end
      cnt_d[sel_ch_q] = cnt_q[sel_ch_q] - cnt_wd'(1);
      brd_d           = 1'b1;
    end

    if (!flush && wr_req && !wr_ok) begin
      ovf_d = 1'b1;
    end
    if (rd_req && !brd_q && empty_q) begin
      udf_d = 1'b1;
    end

    for (int c = 0; c < int'(n_ch); c++) begin
      len_d     = len_d + len_wd'(cnt_d[c]);
      full_d[c] = (cnt_d[c] == cnt_wd'(q_max_len));
    end
    empty_d = (len_d == '0);
  end

  // Selector: earliest head across channels, lowest index wins ties
  always_comb begin
    sel_found = 1'b0;
    sel_d     = sel_q;
    sel_ch_d  = sel_ch_q;
    for (int c = 0; c < int'(n_ch); c++) begin
      if ((cnt_q[c] != '0) &&
          (!sel_found || t_before(mem_q[c][0][hi:lo], sel_d[hi:lo]))) begin
        sel_found = 1'b1;
        sel_d     = mem_q[c][0];
        sel_ch_d  = ch_wd'(c);
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < int'(n_ch); c++) begin
        cnt_q[c] <= '0;
        for (int i = 0; i < int'(q_max_len); i++) begin
          mem_q[c][i] <= '0;
        end
      end
      sel_q    <= '0;
      sel_ch_q <= '0;
      ev_out_q <= '0;
      ev_ch_q  <= '0;
      dv_q     <= 1'b0;
      full_q   <= '0;
      empty_q  <= 1'b1;
      brd_q    <= 1'b0;
      bwr_q    <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      len_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      sel_ch_q <= sel_ch_d;
      ev_out_q <= ev_out_d;
      ev_ch_q  <= ev_ch_d;
      dv_q     <= dv_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      brd_q    <= brd_d;
      bwr_q    <= bwr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      len_q    <= len_d;
    end
  end

  assign EV_out      = ev_out_q;
  assign EV_ch       = ev_ch_q;
  assign dv          = dv_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign busy_for_rd = brd_q;
  assign busy_for_wr = bwr_q;
  assign ovf         = ovf_q;
  assign udf         = udf_q;
  assign length      = len_q;

endmodule

// File: tb/tb_event_queue_mc.sv
// tb_event_queue_mc: directed and random stimulus against a queue-based model.
module tb_event_queue_mc;

  localparam int NCH = 4;
  localparam int QL  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] EV_in;
  logic [1:0]  ch;
  logic        op, cs, flush;
  logic [31:0] EV_out;
  logic [1:0]  EV_ch;
  logic        dv;
  logic [3:0]  full;
  logic        empty, busy_for_rd, busy_for_wr, ovf, udf;
  logic [6:0]  length;

  event_queue_mc dut (
    .clk(clk), .rst(rst), .EV_in(EV_in), .ch(ch), .op(op), .cs(cs),
    .flush(flush), .EV_out(EV_out), .EV_ch(EV_ch), .dv(dv), .full(full),
    .empty(empty), .busy_for_rd(busy_for_rd), .busy_for_wr(busy_for_wr),
    .ovf(ovf), .udf(udf), .length(length)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int seq   = 0;

  // Reference model state
  logic [31:0] mq [NCH][$];
  logic        m_brd, m_bwr, m_dv, m_ovf, m_udf;
  logic [31:0] m_out;
  logic [1:0]  m_ch;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_before(input logic [15:0] a, input logic [15:0] b);
`ifdef EQ_TIME_WRAP_EN
    logic [15:0] d;
    d = a - b;
    return d[15];
`else
    return a < b;
`endif
  endfunction

  function automatic int m_total();
    int t = 0;
    for (int k = 0; k < NCH; k++) t += mq[k].size();
    return t;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) mq[k].delete();
    m_brd = 0; m_bwr = 0; m_dv = 0; m_ovf = 0; m_udf = 0;
  endtask

  // One clock edge of the model
  task automatic model_edge(input logic f, input logic c, input logic o,
                            input logic [1:0] chn, input logic [31:0] d);
    bit nb, nw, found;
    int ci, pos, best;
    logic [31:0] e, h;
    nb = 0; nw = 0;
    m_dv = 0; m_ovf = 0; m_udf = 0;
    ci = int'(chn);
    if (f) begin
      for (int k = 0; k < NCH; k++) mq[k].delete();
      nw = 1;
    end else if (c && o) begin
      if (m_bwr || ci >= NCH || mq[ci].size() >= QL) begin
        m_ovf = 1;
      end else begin
        pos = mq[ci].size();
        found = 0;
        for (int j = 0; j < mq[ci].size(); j++) begin
          e = mq[ci][j];
          if (!found && m_before(d[15:0], e[15:0])) begin
            pos = j;
            found = 1;
          end
        end
        mq[ci].insert(pos, d);
        nb = 1;
      end
    end else if (c && !o && !m_brd) begin
      if (m_total() == 0) begin
        m_udf = 1;
      end else begin
        best = -1;
        h = '0;
        for (int k = 0; k < NCH; k++) begin
          if (mq[k].size() > 0) begin
            e = mq[k][0];
            if (best < 0 || m_before(e[15:0], h[15:0])) begin
              best = k;
              h = e;
            end
          end
        end
        m_out = mq[best].pop_front();
        m_ch  = 2'(best);
        m_dv  = 1;
        nb    = 1;
      end
    end
    m_brd = nb;
    m_bwr = nw;
  endtask

  task automatic check_outs();
    logic [3:0] ef;
    for (int k = 0; k < NCH; k++) ef[k] = (mq[k].size() == QL);
    check_eq("dv", 64'(dv), 64'(m_dv));
    check_eq("ovf", 64'(ovf), 64'(m_ovf));
    check_eq("udf", 64'(udf), 64'(m_udf));
    check_eq("busy_for_rd", 64'(busy_for_rd), 64'(m_brd));
    check_eq("busy_for_wr", 64'(busy_for_wr), 64'(m_bwr));
    check_eq("empty", 64'(empty), 64'(m_total() == 0));
    check_eq("length", 64'(length), 64'(m_total()));
    check_eq("full", 64'(full), 64'(ef));
    if (m_dv) begin
      check_eq("EV_out", 64'(EV_out), 64'(m_out));
      check_eq("EV_ch", 64'(EV_ch), 64'(m_ch));
    end
  endtask

  // Drive one cycle (entered at a falling edge), then check after the edge
  task automatic step(input logic f, input logic c, input logic o,
                      input logic [1:0] chn, input logic [31:0] d);
    flush = f; cs = c; op = o; ch = chn; EV_in = d;
    @(posedge clk);
    model_edge(f, c, o, chn, d);
    @(negedge clk);
    check_outs();
  endtask

  task automatic wr(input logic [1:0] chn, input logic [15:0] t);
    seq++;
    step(1'b0, 1'b1, 1'b1, chn, {16'(seq), t});
  endtask
  task automatic rd();
    step(1'b0, 1'b1, 1'b0, 2'd0, 32'd0);
  endtask
  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask
  task automatic do_flush();
    step(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  logic [15:0] tag_a, tag_b;
  logic [31:0] rv;

  initial begin
    rst = 1'b0; flush = 0; cs = 0; op = 0; ch = 0; EV_in = 0;
    model_reset();
    #12;
    check_outs();
    check_eq("rst_EV_out", 64'(EV_out), 64'd0);
    check_eq("rst_EV_ch", 64'(EV_ch), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Ordered insert on one channel
    wr(2'd0, 16'd30); wr(2'd0, 16'd10); wr(2'd0, 16'd20); idle();
    rd(); rv = EV_out; check_eq("ord_1", 64'(rv[15:0]), 64'd10); idle();
    rd(); rv = EV_out; check_eq("ord_2", 64'(rv[15:0]), 64'd20); idle();
    rd(); rv = EV_out; check_eq("ord_3", 64'(rv[15:0]), 64'd30);
    check_eq("ord_empty", 64'(empty), 64'd1);
    idle();

    // Cross-channel ordering and tie-break
    wr(2'd2, 16'd5); wr(2'd1, 16'd5); wr(2'd0, 16'd7); idle();
    rd(); check_eq("tie_ch1", 64'(EV_ch), 64'd1); idle();
    rd(); check_eq("tie_ch2", 64'(EV_ch), 64'd2); idle();
    rd(); check_eq("tie_ch0", 64'(EV_ch), 64'd0); idle();
    wr(2'd3, 16'd9); tag_a = 16'(seq);
    wr(2'd3, 16'd9); tag_b = 16'(seq);
    idle();
    rd(); rv = EV_out; check_eq("fifo_a", 64'(rv[31:16]), 64'(tag_a)); idle();
    rd(); rv = EV_out; check_eq("fifo_b", 64'(rv[31:16]), 64'(tag_b)); idle();

    // Fill one channel, overflow, other channel still writable
    for (int i = 0; i < QL; i++) wr(2'd1, 16'($urandom_range(0, 100)));
    check_eq("full1", 64'(full[1]), 64'd1);
    check_eq("len16", 64'(length), 64'd16);
    wr(2'd1, 16'd3);
    check_eq("ovf_pulse", 64'(ovf), 64'd1);
    check_eq("ovf_len", 64'(length), 64'd16);
    wr(2'd0, 16'd4);
    check_eq("len17", 64'(length), 64'd17);
    idle(); rd(); idle();
    do_flush(); idle();

    // Underflow and busy read
    rd();
    check_eq("udf_pulse", 64'(udf), 64'd1);
    idle();
    wr(2'd2, 16'd11); rd();
    check_eq("busy_rd_dv", 64'(dv), 64'd0);
    idle();

    // Flush with concurrent write, then dropped write while busy
    for (int i = 0; i < 5; i++) wr(2'($urandom_range(0, 3)), 16'($urandom_range(0, 50)));
    step(1'b1, 1'b1, 1'b1, 2'd0, 32'h55);
    check_eq("fl_len", 64'(length), 64'd0);
    check_eq("fl_bwr", 64'(busy_for_wr), 64'd1);
    wr(2'd0, 16'd1);
    idle();

    // Reset asserted while a read result is presented
    wr(2'd3, 16'd8); idle(); rd();
    #1 rst = 1'b0;
    #1;
    model_reset();
    check_eq("rst_mid_dv", 64'(dv), 64'd0);
    check_outs();
    @(negedge clk);
    rst = 1'b1;

    // TIME counter rollover
    wr(2'd0, 16'hFFF0); wr(2'd0, 16'h0010); idle(); rd();
    rv = EV_out;
`ifdef EQ_TIME_WRAP_EN
    check_eq("wrap_first", 64'(rv[15:0]), 64'hFFF0);
`else
    check_eq("wrap_first", 64'(rv[15:0]), 64'h0010);
`endif
    idle(); rd(); idle();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 199));
      if (r < 2)        do_flush();
      else if (r < 30)  idle();
      else if (r < 120) wr(2'($urandom_range(0, 3)), 16'($urandom_range(0, 40)));
      else              rd();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
